// File: rtl/alien_pkg.sv
// rtl/alien_pkg.sv - shared motion codes, sequencer states and default swarm geometry
package alien_pkg;

    typedef enum logic [1:0] {
        NO_MOTION = 2'd0,
        LEFT      = 2'd1,
        RIGHT     = 2'd2,
        DOWN      = 2'd3
    } motion_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_STEP  = 3'd2,
        ST_APPLY = 3'd3,
        ST_HALT  = 3'd4
    } state_e;

    localparam int DEF_X_W           = 10;
    localparam int DEF_Y_W           = 9;
    localparam int DEF_X_START       = 16;
    localparam int DEF_Y_START       = 64;
    localparam int DEF_X_LEFT_LIMIT  = 16;
    localparam int DEF_X_RIGHT_LIMIT = 624;
    localparam int DEF_SWARM_W       = 352;
    localparam int DEF_STEP_X        = 8;
    localparam int DEF_STEP_Y        = 16;
    localparam int DEF_Y_INVADE      = 400;
    localparam int DEF_PERIOD_MIN    = 2;
    localparam int DEF_CNT_W         = 6;

endpackage

// File: rtl/march_timer.sv
// rtl/march_timer.sv - frame counter that flags when the next march step is due
module march_timer #(
    parameter int CNT_W      = 6,
    parameter int PERIOD_MIN = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic             frame_tick,
    input  logic             pause,
    input  logic [CNT_W-1:0] alive_count,
    output logic             step_due
);
    localparam int PW = CNT_W + 2;

    logic [CNT_W-1:0] cnt_q;
    logic [PW-1:0]    cnt_inc;
    logic [PW-1:0]    period;
    logic             tick_ok;

    // Two extra bits keep PERIOD_MIN + alive_count - 1 from wrapping.
    assign cnt_inc  = {2'b00, cnt_q} + PW'(1);
    assign period   = PW'(PERIOD_MIN) + {2'b00, alive_count} - PW'(1);
    assign tick_ok  = enable & frame_tick & ~pause;
    assign step_due = tick_ok && (cnt_inc >= period);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (step_due) begin
            cnt_q <= '0;
        end else if (tick_ok) begin
            cnt_q <= cnt_inc[CNT_W-1:0];
        end
    end

endmodule

// File: rtl/alien_march_sequencer.sv
// rtl/alien_march_sequencer.sv - paces swarm steps, applies motion codes, detects invasion/clear
module alien_march_sequencer
    import alien_pkg::*;
#(
    parameter int X_W           = DEF_X_W,
    parameter int Y_W           = DEF_Y_W,
    parameter int X_START       = DEF_X_START,
    parameter int Y_START       = DEF_Y_START,
    parameter int X_LEFT_LIMIT  = DEF_X_LEFT_LIMIT,
    parameter int X_RIGHT_LIMIT = DEF_X_RIGHT_LIMIT,
    parameter int SWARM_W       = DEF_SWARM_W,
    parameter int STEP_X        = DEF_STEP_X,
    parameter int STEP_Y        = DEF_STEP_Y,
    parameter int Y_INVADE      = DEF_Y_INVADE,
    parameter int PERIOD_MIN    = DEF_PERIOD_MIN,
    parameter int CNT_W         = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             frame_tick,
    input  logic             start,
    input  logic             pause,
    input  logic [CNT_W-1:0] alive_count,
    input  logic [1:0]       motion,
    output logic             step_en,
    output logic             zz_clear,
    output logic             can_left,
    output logic             can_right,
    output logic [X_W-1:0]   swarm_x,
    output logic [Y_W-1:0]   swarm_y,
    output logic             busy,
    output logic             invaded,
    output logic             cleared
);
    localparam int XW1 = X_W + 1;
    localparam int YW1 = Y_W + 1;

    state_e         state_q;
    logic [X_W-1:0] swarm_x_q;
    logic [Y_W-1:0] swarm_y_q;
    logic           step_en_q;
    logic           zz_clear_q;
    logic           busy_q;
    logic           invaded_q;
    logic           cleared_q;

    logic           step_due;
    logic           timer_en;
    logic           running;
    logic [XW1-1:0] x_wide;
    logic           can_left_raw;
    logic           can_right_raw;
    logic [X_W-1:0] x_left_d;
    logic [X_W-1:0] x_right_d;
    logic [YW1-1:0] y_down_wide;
    logic [Y_W-1:0] y_down_d;

    assign timer_en = (state_q == ST_WAIT) && (alive_count != '0);

    march_timer #(
        .CNT_W      (CNT_W),
        .PERIOD_MIN (PERIOD_MIN)
    ) u_timer (
        .clk         (clk),
        .reset       (reset),
        .clear       (start),
        .enable      (timer_en),
        .frame_tick  (frame_tick),
        .pause       (pause),
        .alive_count (alive_count),
        .step_due    (step_due)
    );

    assign running       = (state_q == ST_WAIT) || (state_q == ST_STEP) || (state_q == ST_APPLY);
    assign x_wide        = {1'b0, swarm_x_q};
    assign can_left_raw  = x_wide >= XW1'(X_LEFT_LIMIT + STEP_X);
    assign can_right_raw = (x_wide + XW1'(SWARM_W + STEP_X)) <= XW1'(X_RIGHT_LIMIT);
    assign x_left_d      = swarm_x_q - X_W'(STEP_X);
    assign x_right_d     = swarm_x_q + X_W'(STEP_X);
    // A DOWN step pins at the top of the Y range rather than wrapping.
    assign y_down_wide   = {1'b0, swarm_y_q} + YW1'(STEP_Y);
    assign y_down_d      = y_down_wide[Y_W] ? {Y_W{1'b1}} : y_down_wide[Y_W-1:0];

    always_ff @(posedge clk) begin
        step_en_q  <= 1'b0;
        zz_clear_q <= 1'b0;
        cleared_q  <= 1'b0;
        if (reset) begin
            state_q   <= ST_IDLE;
            swarm_x_q <= X_W'(X_START);
            swarm_y_q <= Y_W'(Y_START);
            busy_q    <= 1'b0;
            invaded_q <= 1'b0;
        end else if (state_q == ST_WAIT && alive_count == '0) begin
            state_q   <= ST_IDLE;
            busy_q    <= 1'b0;
            cleared_q <= 1'b1;
        end else if (start) begin
            state_q    <= ST_WAIT;
            swarm_x_q  <= X_W'(X_START);
            swarm_y_q  <= Y_W'(Y_START);
            busy_q     <= 1'b1;
            invaded_q  <= 1'b0;
            zz_clear_q <= 1'b1;
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (step_due) begin
                        state_q   <= ST_STEP;
                        step_en_q <= 1'b1;
                    end
                end
                ST_STEP: state_q <= ST_APPLY;
                ST_APPLY: begin
                    state_q <= ST_WAIT;
                    case (motion_e'(motion))
                        LEFT:  if (can_left_raw)  swarm_x_q <= x_left_d;
                        RIGHT: if (can_right_raw) swarm_x_q <= x_right_d;
                        DOWN: begin
                            swarm_y_q <= y_down_d;
                            if (y_down_d >= Y_W'(Y_INVADE)) begin
                                invaded_q <= 1'b1;
                                busy_q    <= 1'b0;
                                state_q   <= ST_HALT;
                            end
                        end
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign step_en   = step_en_q;
    assign zz_clear  = zz_clear_q;
    assign cleared   = cleared_q;
    assign busy      = busy_q;
    assign invaded   = invaded_q;
    assign swarm_x   = swarm_x_q;
    assign swarm_y   = swarm_y_q;
    assign can_left  = running & can_left_raw;
    assign can_right = running & can_right_raw;

endmodule

// File: doc/alien_march_sequencer.md
Name: alien_march_sequencer

Overview:
Schedules the alien swarm's march. Counts frame ticks and issues one-cycle step enables to the zig-zag motion FSM. The step period shrinks as aliens die. Applies the returned motion code to the swarm X/Y offset registers and feeds can_left/can_right back to the FSM. Detects "invaded" (swarm reached the defender row) and "wave cleared" (no aliens alive). Sits between the frame timing generator, the alien-kill bookkeeping and the motion FSM/renderer.

Parameters:
X_W, 10, width of swarm_x
Y_W, 9, width of swarm_y
X_START, 16, swarm_x loaded on start
Y_START, 64, swarm_y loaded on start
X_LEFT_LIMIT, 16, minimum legal swarm_x
X_RIGHT_LIMIT, 624, maximum legal swarm_x + SWARM_W
SWARM_W, 352, swarm width in pixels
STEP_X, 8, pixels per LEFT/RIGHT step
STEP_Y, 16, pixels per DOWN step
Y_INVADE, 400, swarm_y at or beyond which the wave is lost
PERIOD_MIN, 2, frames between steps when one alien is left
CNT_W, 6, width of alive_count and the frame counter

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; all state cleared on the clock edge where it is high
frame_tick  in  1  one-cycle pulse per video frame
start  in  1  one-cycle pulse that begins a wave
pause  in  1  level; freezes the march
alive_count  in  CNT_W  number of live aliens
motion  in  2  code from the motion FSM: 0 NO_MOTION, 1 LEFT, 2 RIGHT, 3 DOWN
step_en  out  1  enable to the motion FSM, one-cycle pulse
zz_clear  out  1  one-cycle reset to the motion FSM on start
can_left  out  1  a further LEFT step stays within limits
can_right  out  1  a further RIGHT step stays within limits
swarm_x  out  X_W  swarm left edge
swarm_y  out  Y_W  swarm top edge
busy  out  1  wave in progress
invaded  out  1  sticky; the swarm reached Y_INVADE
cleared  out  1  one-cycle pulse; all aliens dead

Behaviour:
- Reset values: all outputs 0; swarm_x = X_START; swarm_y = Y_START; state IDLE; frame counter 0.
- States: IDLE, WAIT, STEP, APPLY, HALT.
- IDLE:
  - On start: load X_START/Y_START, clear invaded, pulse zz_clear for 1 cycle, clear the counter, go to WAIT.
  - busy = 0.
- WAIT:
  - busy = 1.
  - If alive_count == 0: pulse cleared, go to IDLE. This check takes priority over everything else.
  - Otherwise, on frame_tick with pause low: counter++.
  - When counter+1 >= PERIOD_MIN + alive_count - 1 on that tick: clear the counter and go to STEP.
  - pause holds the counter and blocks stepping.
- STEP: step_en = 1 for exactly this cycle, then go to APPLY.
  - The motion FSM registers its motion on this edge; motion is valid only in the following cycle.
- APPLY: sample motion.
  - LEFT: swarm_x -= STEP_X.
  - RIGHT: swarm_x += STEP_X.
  - DOWN: swarm_y += STEP_Y. If the new swarm_y >= Y_INVADE: set invaded, go to HALT.
  - NO_MOTION: no change.
  - Otherwise go to WAIT.
- HALT:
  - busy = 0, invaded held.
  - Leave only on start (same as the start action in IDLE) or on reset.
- Step latency: frame_tick → step_en is 1 cycle; step_en → position update is 2 cycles.
- can_left = (swarm_x >= X_LEFT_LIMIT + STEP_X).
- can_right = (swarm_x + SWARM_W + STEP_X <= X_RIGHT_LIMIT).
  - Both are combinational from the registers.
  - Compute at X_W+1 bits so there is no wrap.
  - Both are held 0 in IDLE and HALT.
- Position arithmetic saturates at the limits; overflow is never allowed. A LEFT/RIGHT received while the matching can_* = 0 is ignored.
- start in WAIT, STEP or APPLY restarts the wave, same as from IDLE.
- A frame_tick coincident with STEP or APPLY is dropped; it is not counted.
- reset mid-operation wins over every other input.

Decomposition:
- Package alien_pkg holds:
  - motion codes NO_MOTION, LEFT, RIGHT, DOWN (2 bits)
  - state encoding
  - default geometry constants shared with the renderer
- One sub-module, march_timer: the frame counter plus the period compare. It outputs step_due.

Test Plan:
1. reset, then start, alive_count = 55, PERIOD_MIN = 2 → zz_clear pulse; first step_en after the 56th frame_tick; swarm_x = 16.
2. Stub FSM returns RIGHT every step, alive_count = 1 → step_en every 2 ticks; swarm_x goes 16, 24, … 272. can_right drops to 0 at swarm_x = 272.
3. DOWN repeatedly from Y_START = 64 → swarm_y 80 … 400. At 400: invaded = 1, busy = 0, step_en stops until the next start.
4. alive_count set to 0 mid-WAIT → cleared for 1 cycle, state IDLE, no further step_en.
5. pause high for 10 frame_ticks → no step_en, counter frozen; stepping resumes with the remaining count.
6. reset asserted during APPLY with motion = RIGHT → swarm_x returns to 16; all outputs 0 on the next cycle.
